// File: rtl/if_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// if_fetch_stage_if : instruction SRAM port plus IF->ID handshake bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface if_fetch_stage_if #(
  parameter int PC_W = 32
);
  logic            inst_sram_we;
  logic [PC_W-1:0] inst_sram_addr;
  logic [31:0]     inst_sram_wdata;
  logic [31:0]     inst_sram_rdata;

  logic            ds_allowin;
  logic            br_taken;
  logic [PC_W-1:0] br_target;

  logic            fs_to_ds_valid;
  logic [PC_W-1:0] fs_to_ds_pc;
  logic [31:0]     fs_to_ds_inst;

  modport master (
    output inst_sram_we,
    output inst_sram_addr,
    output inst_sram_wdata,
    input  inst_sram_rdata,
    input  ds_allowin,
    input  br_taken,
    input  br_target,
    output fs_to_ds_valid,
    output fs_to_ds_pc,
    output fs_to_ds_inst
  );

  modport slave (
    input  inst_sram_we,
    input  inst_sram_addr,
    input  inst_sram_wdata,
    output inst_sram_rdata,
    output ds_allowin,
    output br_taken,
    output br_target,
    input  fs_to_ds_valid,
    input  fs_to_ds_pc,
    input  fs_to_ds_inst
  );
endinterface

`default_nettype wire

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage : pre-IF/IF stage, nextpc generation, SRAM latency skid buffer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module if_fetch_stage #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h1c00_0000
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  if_fetch_stage_if.master  fs
);

  localparam logic [PC_W-1:0] c_pc_step = PC_W'(4);

  logic            r_pf_valid;
  logic            r_fs_valid;
  logic [PC_W-1:0] r_fs_pc;
  logic            r_buf_valid;
  logic [31:0]     r_buf_inst;

  logic            w_br;
  logic            w_fs_allowin;
  logic            w_accept;
  logic            w_capture;
  logic [PC_W-1:0] w_nextpc;

  // Branches are meaningless before pre-IF is live, so RESET_PC is always fetched first.
  assign w_br         = fs.br_taken & r_pf_valid;
  assign w_nextpc     = w_br ? fs.br_target : (r_fs_pc + c_pc_step);
  assign w_fs_allowin = ~r_fs_valid | fs.ds_allowin;
  assign w_accept     = r_pf_valid & (w_fs_allowin | fs.br_taken);
  assign w_capture    = r_fs_valid & ~fs.ds_allowin & ~r_buf_valid & ~fs.br_taken;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pf_valid  <= 1'b0;
      r_fs_valid  <= 1'b0;
      r_fs_pc     <= RESET_PC - c_pc_step;
      r_buf_valid <= 1'b0;
      r_buf_inst  <= 32'd0;
    end else begin
      r_pf_valid <= 1'b1;
      if (w_accept) begin
        r_fs_valid  <= 1'b1;
        r_fs_pc     <= w_nextpc;
        r_buf_valid <= 1'b0;
      end else if (w_capture) begin
        // SRAM output moves on to nextpc after this edge; keep the stalled word.
        r_buf_valid <= 1'b1;
        r_buf_inst  <= fs.inst_sram_rdata;
      end
    end
  end

  assign fs.inst_sram_we   = 1'b0;
  assign fs.inst_sram_wdata = 32'd0;
  assign fs.inst_sram_addr = w_nextpc;

  assign fs.fs_to_ds_valid = r_fs_valid & ~fs.br_taken;
  assign fs.fs_to_ds_pc    = r_fs_pc;
  assign fs.fs_to_ds_inst  = r_buf_valid ? r_buf_inst : fs.inst_sram_rdata;

endmodule

`default_nettype wire
